// File: rtl/multi_ch_sync_filter_pkg.sv
// Shared types and helpers for the multi-channel synchroniser / glitch filter.
package cdc_sync_pkg;

   typedef enum logic [1:0] {EDGE_NONE, EDGE_RISE, EDGE_FALL} edge_e;

   function automatic int cnt_w(int filter_cyc);
      return $clog2(filter_cyc + 1);
   endfunction

endpackage

// File: rtl/multi_ch_sync_filter_ch.sv
// One channel: sync flop chain, stability counter, filtered level, edge pulses.
// Sticky edge flags exist only when CDC_SYNC_STICKY_EN is defined.
module sync_filter_ch
   import cdc_sync_pkg::*;
#(
   parameter int   SYNC_STAGES = 2,
   parameter int   FILTER_CYC  = 4,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   input  logic clr,
   output logic q,
   output logic rise,
   output logic fall,
   output logic sticky_rise,
   output logic sticky_fall
);

   localparam int            CW   = cnt_w(FILTER_CYC);
   localparam logic [CW-1:0] LAST = CW'(FILTER_CYC - 1);

   logic [SYNC_STAGES-1:0] stg;
   logic                   s;
   logic [CW-1:0]          cnt;
   logic [CW-1:0]          cnt_d;
   logic                   q_d;
   edge_e                  edge_d;

   assign s = stg[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (!rst_n) stg <= {SYNC_STAGES{RST_VAL}};
      else        stg <= {stg[SYNC_STAGES-2:0], din};
   end

   // A level must differ from q for FILTER_CYC consecutive samples before q follows.
   always_comb begin
      cnt_d  = cnt;
      q_d    = q;
      edge_d = EDGE_NONE;
      if (s == q) begin
         cnt_d = '0;
      end else if (cnt == LAST) begin
         cnt_d  = '0;
         q_d    = s;
         edge_d = s ? EDGE_RISE : EDGE_FALL;
      end else begin
         cnt_d = cnt + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q    <= RST_VAL;
         cnt  <= '0;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         q    <= q_d;
         cnt  <= cnt_d;
         rise <= (edge_d == EDGE_RISE);
         fall <= (edge_d == EDGE_FALL);
      end
   end

`ifdef CDC_SYNC_STICKY_EN
   // Flags set on the same edge as the pulse; a coincident clear loses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sticky_rise <= 1'b0;
         sticky_fall <= 1'b0;
      end else begin
         sticky_rise <= (sticky_rise & ~clr) | (edge_d == EDGE_RISE);
         sticky_fall <= (sticky_fall & ~clr) | (edge_d == EDGE_FALL);
      end
   end
`else
   logic unused_clr;
   assign unused_clr  = clr;
   assign sticky_rise = 1'b0;
   assign sticky_fall = 1'b0;
`endif

endmodule

// File: rtl/multi_ch_sync_filter.sv
// Multi-channel async-input synchroniser with glitch filter and edge detection.
// Optional sticky edge flags: define CDC_SYNC_STICKY_EN.
module multi_ch_sync_filter #(
   parameter int                NUM_CH      = 4,
   parameter int                SYNC_STAGES = 2,
   parameter int                FILTER_CYC  = 4,
   parameter logic [NUM_CH-1:0] RST_VAL     = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] din,
   output logic [NUM_CH-1:0] q_o,
   output logic [NUM_CH-1:0] rise_o,
   output logic [NUM_CH-1:0] fall_o,
   input  logic [NUM_CH-1:0] clr_i,
   output logic [NUM_CH-1:0] sticky_rise_o,
   output logic [NUM_CH-1:0] sticky_fall_o
);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      sync_filter_ch #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILTER_CYC  (FILTER_CYC),
         .RST_VAL     (RST_VAL[c])
      ) u_ch (
         .clk         (clk),
         .rst_n       (rst_n),
         .din         (din[c]),
         .clr         (clr_i[c]),
         .q           (q_o[c]),
         .rise        (rise_o[c]),
         .fall        (fall_o[c]),
         .sticky_rise (sticky_rise_o[c]),
         .sticky_fall (sticky_fall_o[c])
      );
   end

endmodule

// File: tb/tb_multi_ch_sync_filter.sv
// Scoreboard bench: sliding-window reference model predicts every cycle's outputs.
module tb_multi_ch_sync_filter;

   localparam int         NC = 4;
   localparam int         SS = 2;
   localparam int         FC = 4;
   localparam logic [3:0] RV = 4'b1010;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic [NC-1:0] din   = RV;
   logic [NC-1:0] clr   = '0;
   logic [NC-1:0] q_o, rise_o, fall_o, sticky_rise_o, sticky_fall_o;

   always #5 clk = ~clk;

   multi_ch_sync_filter #(
      .NUM_CH      (NC),
      .SYNC_STAGES (SS),
      .FILTER_CYC  (FC),
      .RST_VAL     (RV)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .din           (din),
      .q_o           (q_o),
      .rise_o        (rise_o),
      .fall_o        (fall_o),
      .clr_i         (clr),
      .sticky_rise_o (sticky_rise_o),
      .sticky_fall_o (sticky_fall_o)
   );

   // Model: din delayed SS samples, q follows once the last FC delayed samples all differ from it.
   logic [NC-1:0] m_sync [SS];
   logic [NC-1:0] m_win  [FC];
   logic [NC-1:0] m_q, m_r, m_f, m_sr, m_sf;
   logic [5*NC-1:0] exp_q [$];
   int compared   = 0;
   int mismatched = 0;

   task automatic model_step(input logic rst_s, input logic [NC-1:0] din_s, input logic [NC-1:0] clr_s);
      logic [NC-1:0] s, alldiff;
      if (!rst_s) begin
         for (int i = 0; i < SS; i++) m_sync[i] = RV;
         for (int i = 0; i < FC; i++) m_win[i] = RV;
         m_q = RV; m_r = '0; m_f = '0; m_sr = '0; m_sf = '0;
      end else begin
         s = m_sync[SS-1];
         for (int i = FC-1; i > 0; i--) m_win[i] = m_win[i-1];
         m_win[0] = s;
         alldiff = '1;
         for (int i = 0; i < FC; i++) alldiff = alldiff & (m_win[i] ^ m_q);
         m_r = alldiff & s;
         m_f = alldiff & ~s;
         m_q = (m_q & ~alldiff) | (s & alldiff);
`ifdef CDC_SYNC_STICKY_EN
         m_sr = (m_sr & ~clr_s) | m_r;
         m_sf = (m_sf & ~clr_s) | m_f;
`else
         m_sr = '0; m_sf = '0;
`endif
         for (int i = SS-1; i > 0; i--) m_sync[i] = m_sync[i-1];
         m_sync[0] = din_s;
      end
      exp_q.push_back({m_q, m_r, m_f, m_sr, m_sf});
   endtask

   initial forever begin
      @(posedge clk);
      model_step(rst_n, din, clr);
   end

   initial forever begin : monitor
      logic [5*NC-1:0] e, got;
      @(negedge clk);
      got = {q_o, rise_o, fall_o, sticky_rise_o, sticky_fall_o};
      compared++;
      if (exp_q.size() == 0) begin
         mismatched++;
         $display("FAIL sb_empty t=%0t got=%h required=<entry>", $time, got);
      end else begin
         e = exp_q.pop_front();
         if (got !== e) begin
            mismatched++;
            $display("FAIL outputs t=%0t q/rise/fall/srise/sfall got=%h required=%h", $time, got, e);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      // Reset with din at the reset value, then swap every channel's level.
      rst_n = 1'b0; din = RV; tick(3);
      rst_n = 1'b1; tick(10);
      din = 4'b0101; tick(10);
      din = RV;      tick(10);
      // Latency on ch0.
      din[0] = 1'b1; tick(10);
      din[0] = 1'b0; tick(10);
      // Glitches of 3 (rejected) and 4 (accepted) cycles on ch1 and ch0.
      din[1] = 1'b0; din[0] = 1'b1; tick(3);
      din[1] = 1'b1; din[0] = 1'b0; tick(10);
      din[1] = 1'b0; din[0] = 1'b1; tick(4);
      din[1] = 1'b1; din[0] = 1'b0; tick(12);
      // Reset in the middle of a count on ch2.
      din[2] = 1'b1; tick(4);
      rst_n = 1'b0;  tick(1);
      rst_n = 1'b1;  tick(12);
      din[2] = 1'b0; tick(10);
      // Sticky behaviour on ch3: set, hold, clear, coincident set/clear.
      din[3] = 1'b0; tick(10);
      din[3] = 1'b1; tick(16);
      clr[3] = 1'b1; tick(1);
      clr[3] = 1'b0; tick(4);
      din[3] = 1'b0; tick(10);
      clr = '1;      tick(1);
      clr = '0;
      din[3] = 1'b1; tick(5);
      clr[3] = 1'b1; tick(1);
      clr[3] = 1'b0; tick(10);
      // Randomised traffic: mixed short glitches and held levels, random clears and resets.
      for (int n = 0; n < 2000; n++) begin
         if ($urandom_range(3) == 0) din[$urandom_range(NC-1)] ^= 1'b1;
         clr   = ($urandom_range(15) == 0) ? NC'($urandom) : '0;
         rst_n = ($urandom_range(299) != 0);
         tick(1);
      end
      rst_n = 1'b1; clr = '0; tick(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout t=%0t", $time);
      $fatal(1);
   end

endmodule
